// File: rtl/pool2d_engine.sv
`default_nettype none
// ============================================================================
// Module : pool2d_engine
// 2x2 / stride-2 max or floor-average pooling over streamed BRAM row pairs.
// Rev    : 1.0
// ============================================================================
module pool2d_engine #(
  parameter int BD       = 18,
  parameter int CH       = 3,
  parameter int IN_W     = 28,
  parameter int IN_H     = 28,
  parameter int NUM_MAPS = 3,
  parameter int MODE     = 0,
  localparam int COL_W   = $clog2(IN_W),
  localparam int ROW_W   = (IN_H / 2 > 1) ? $clog2(IN_H / 2) : 1,
  localparam int MAP_W   = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
  localparam int ADDR_W  = (IN_H * IN_W / 4 > 1) ? $clog2(IN_H * IN_W / 4) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hold,
  input  logic [CH*BD-1:0]     q0,
  input  logic [CH*BD-1:0]     q1,
  output logic                 rd_en,
  output logic [COL_W-1:0]     rd_col,
  output logic [ROW_W-1:0]     rd_row,
  output logic [MAP_W-1:0]     rd_map,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [MAP_W-1:0]     wr_map,
  output logic [CH*BD-1:0]     d,
  output logic                 busy,
  output logic                 done
);

  localparam logic [COL_W-1:0] c_col_last = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IN_H / 2 - 1);
  localparam logic [MAP_W-1:0] c_map_last = MAP_W'(NUM_MAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_pair;
  logic                w_map_end;
  logic                w_last_issue;

  logic                r_p1_valid;
  logic                r_p1_odd;
  logic [MAP_W-1:0]    r_p1_map;
  logic [ADDR_W-1:0]   r_p1_addr;

  logic                w_even_load;
  logic                w_odd_fire;
  logic [CH*BD-1:0]    w_result;

  assign w_map_end    = (rd_col == c_col_last) && (rd_row == c_row_last);
  assign w_last_issue = w_map_end && (rd_map == c_map_last);

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        rd_en = !hold;
        if (!hold && w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The tag stage empties in the same cycle the final write appears.
        if (!r_p1_valid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ address counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_col <= '0;
      rd_row <= '0;
      rd_map <= '0;
      r_pair <= '0;
    end else if (r_state == S_IDLE && start) begin
      rd_col <= '0;
      rd_row <= '0;
      rd_map <= '0;
      r_pair <= '0;
    end else if (rd_en) begin
      if (rd_col == c_col_last) begin
        rd_col <= '0;
        if (rd_row == c_row_last) begin
          rd_row <= '0;
          rd_map <= (rd_map == c_map_last) ? '0 : rd_map + MAP_W'(1);
        end else begin
          rd_row <= rd_row + ROW_W'(1);
        end
      end else begin
        rd_col <= rd_col + COL_W'(1);
      end
      // Output address advances once per column pair, restarting each map.
      if (rd_col[0]) begin
        r_pair <= w_map_end ? '0 : r_pair + ADDR_W'(1);
      end
    end
  end

  // ------------------------------------------- tag stage (aligned with q0/q1)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_valid <= 1'b0;
      r_p1_odd   <= 1'b0;
      r_p1_map   <= '0;
      r_p1_addr  <= '0;
    end else begin
      r_p1_valid <= rd_en;
      if (rd_en) begin
        r_p1_odd  <= rd_col[0];
        r_p1_map  <= rd_map;
        r_p1_addr <= r_pair;
      end
    end
  end

  assign w_even_load = r_p1_valid && !r_p1_odd;
  assign w_odd_fire  = r_p1_valid &&  r_p1_odd;

  // ---------------------------------------------------- per-channel datapath
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic signed [BD-1:0] w_a;
    logic signed [BD-1:0] w_b;

    assign w_a = q0[k*BD +: BD];
    assign w_b = q1[k*BD +: BD];

    if (MODE == 0) begin : g_max
      logic signed [BD-1:0] w_pmax;
      logic signed [BD-1:0] r_v;

      assign w_pmax = (w_a > w_b) ? w_a : w_b;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_v <= '0;
        end else if (w_even_load) begin
          r_v <= w_pmax;
        end
      end

      assign w_result[k*BD +: BD] = (r_v > w_pmax) ? r_v : w_pmax;
    end else begin : g_avg
      logic signed [BD:0]   r_s;
      logic signed [BD+1:0] w_sum;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_s <= '0;
        end else if (w_even_load) begin
          r_s <= {w_a[BD-1], w_a} + {w_b[BD-1], w_b};
        end
      end

      assign w_sum = {r_s[BD], r_s}
                   + {{2{w_a[BD-1]}}, w_a}
                   + {{2{w_b[BD-1]}}, w_b};

      // Floor of a four-value mean always fits back into BD bits.
      assign w_result[k*BD +: BD] = BD'(w_sum >>> 2);
    end
  end

  // ------------------------------------------------------------ write stage
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_map  <= '0;
      d       <= '0;
    end else begin
      wr_en <= w_odd_fire;
      if (w_odd_fire) begin
        wr_addr <= r_p1_addr;
        wr_map  <= r_p1_map;
        d       <= w_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool2d_engine.sv
`default_nettype none
// Bench for pool2d_engine: max and average instances share control, random BRAM
// contents and hold patterns, and are checked every cycle against a pooling model.
module tb_pool2d_engine;

  localparam int BD       = 18;
  localparam int CH       = 3;
  localparam int IN_W     = 28;
  localparam int IN_H     = 28;
  localparam int NUM_MAPS = 3;
  localparam int DW       = CH * BD;
  localparam int READS    = NUM_MAPS * (IN_H / 2) * IN_W;
  localparam int PER_MAP  = IN_H * IN_W / 4;
  localparam int WRITES   = NUM_MAPS * PER_MAP;
  localparam int PW       = IN_W / 2;
  localparam int VMIN     = -(1 << (BD - 1));
  localparam int VMAX     = (1 << (BD - 1)) - 1;

  logic clk = 1'b0;
  logic reset, start, hold;
  always #5 clk = ~clk;

  logic          rd_en_m, wr_en_m, busy_m, done_m;
  logic [4:0]    rd_col_m;
  logic [3:0]    rd_row_m;
  logic [1:0]    rd_map_m, wr_map_m;
  logic [7:0]    wr_addr_m;
  logic [DW-1:0] d_m, q0_m, q1_m;

  logic          rd_en_a, wr_en_a, busy_a, done_a;
  logic [4:0]    rd_col_a;
  logic [3:0]    rd_row_a;
  logic [1:0]    rd_map_a, wr_map_a;
  logic [7:0]    wr_addr_a;
  logic [DW-1:0] d_a, q0_a, q1_a;

  pool2d_engine #(.BD(BD), .CH(CH), .IN_W(IN_W), .IN_H(IN_H), .NUM_MAPS(NUM_MAPS), .MODE(0)) u_max (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .q0(q0_m), .q1(q1_m),
    .rd_en(rd_en_m), .rd_col(rd_col_m), .rd_row(rd_row_m), .rd_map(rd_map_m),
    .wr_en(wr_en_m), .wr_addr(wr_addr_m), .wr_map(wr_map_m), .d(d_m),
    .busy(busy_m), .done(done_m));

  pool2d_engine #(.BD(BD), .CH(CH), .IN_W(IN_W), .IN_H(IN_H), .NUM_MAPS(NUM_MAPS), .MODE(1)) u_avg (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .q0(q0_a), .q1(q1_a),
    .rd_en(rd_en_a), .rd_col(rd_col_a), .rd_row(rd_row_a), .rd_map(rd_map_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_map(wr_map_a), .d(d_a),
    .busy(busy_a), .done(done_a));

  // Feature-map storage; BRAMs return data one cycle after the read, garbage otherwise.
  logic [DW-1:0] mem [NUM_MAPS][IN_H][IN_W];

  always @(posedge clk) begin
    if (rd_en_m) begin
      q0_m <= mem[rd_map_m][2*rd_row_m][rd_col_m];
      q1_m <= mem[rd_map_m][2*rd_row_m+1][rd_col_m];
    end else begin
      q0_m <= DW'({$urandom(), $urandom()});
      q1_m <= DW'({$urandom(), $urandom()});
    end
  end

  always @(posedge clk) begin
    if (rd_en_a) begin
      q0_a <= mem[rd_map_a][2*rd_row_a][rd_col_a];
      q1_a <= mem[rd_map_a][2*rd_row_a+1][rd_col_a];
    end else begin
      q0_a <= DW'({$urandom(), $urandom()});
      q1_a <= DW'({$urandom(), $urandom()});
    end
  end

  // ------------------------------------------------------------------ model
  function automatic int sx(input logic [DW-1:0] w, input int k);
    logic signed [BD-1:0] v;
    v = w[k*BD +: BD];
    return int'(v);
  endfunction

  function automatic logic [DW-1:0] pool_ref(input int m, input int r, input int c, input bit avg);
    logic [DW-1:0] res;
    int v[4];
    int s, mx, f;
    res = '0;
    for (int k = 0; k < CH; k++) begin
      v[0] = sx(mem[m][2*r][2*c], k);
      v[1] = sx(mem[m][2*r][2*c+1], k);
      v[2] = sx(mem[m][2*r+1][2*c], k);
      v[3] = sx(mem[m][2*r+1][2*c+1], k);
      s  = 0;
      mx = v[0];
      for (int i = 0; i < 4; i++) begin
        s += v[i];
        if (v[i] > mx) mx = v[i];
      end
      f = s / 4;
      if ((s % 4) != 0 && s < 0) f -= 1;
      res[k*BD +: BD] = avg ? f[BD-1:0] : mx[BD-1:0];
    end
    return res;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // --------------------------------------------------- per-cycle comparison
  int  cyc = 0;
  always @(posedge clk) cyc++;

  bit  chk_en    = 1'b0;
  bit  exp_rd_en = 1'b0;
  int  exp_col, exp_row, exp_map;
  int  busy_from = -1;
  int  busy_to   = -1;
  int  wr_due[$];
  int  windex    = 0;
  int  wcount_m  = 0;
  int  wcount_a  = 0;
  int  map_cnt[NUM_MAPS];
  int  done_cyc  = -1;
  logic [DW-1:0] cap_m[2];
  logic [DW-1:0] cap_a[2];

  always @(negedge clk) begin : p_cmp
    bit exp_busy, exp_wr;
    int m, a;
    logic [DW-1:0] e_m, e_a;
    if (chk_en) begin
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      exp_wr   = (wr_due.size() > 0) && (wr_due[0] == cyc);
      if (exp_wr) void'(wr_due.pop_front());

      check("max.rd_en", rd_en_m, exp_rd_en);
      check("avg.rd_en", rd_en_a, exp_rd_en);
      if (exp_rd_en) begin
        check("max.rd_col", rd_col_m, exp_col);
        check("max.rd_row", rd_row_m, exp_row);
        check("max.rd_map", rd_map_m, exp_map);
        check("avg.rd_col", rd_col_a, exp_col);
        check("avg.rd_row", rd_row_a, exp_row);
        check("avg.rd_map", rd_map_a, exp_map);
      end
      check("max.busy", busy_m, exp_busy);
      check("avg.busy", busy_a, exp_busy);
      check("max.done", done_m, (busy_from >= 0) && (cyc == busy_to));
      check("avg.done", done_a, (busy_from >= 0) && (cyc == busy_to));
      check("max.wr_en", wr_en_m, exp_wr);
      check("avg.wr_en", wr_en_a, exp_wr);

      if (done_m) done_cyc = cyc;
      if (wr_en_m) begin
        wcount_m++;
        if (wr_map_m < NUM_MAPS) map_cnt[wr_map_m]++;
      end
      if (wr_en_a) wcount_a++;

      if (exp_wr) begin
        m   = windex / PER_MAP;
        a   = windex % PER_MAP;
        e_m = pool_ref(m, a / PW, a % PW, 1'b0);
        e_a = pool_ref(m, a / PW, a % PW, 1'b1);
        if (wr_en_m) begin
          check("max.wr_map", wr_map_m, m);
          check("max.wr_addr", wr_addr_m, a);
          check("max.d", d_m, e_m);
        end
        if (wr_en_a) begin
          check("avg.wr_map", wr_map_a, m);
          check("avg.wr_addr", wr_addr_a, a);
          check("avg.d", d_a, e_a);
        end
        if (windex < 2) begin
          cap_m[windex] = d_m;
          cap_a[windex] = d_a;
        end
        windex++;
      end
    end
  end

  // ----------------------------------------------------------------- driver
  // Caller must be just after a rising edge. Returns early with reset raised
  // once 100 writes have been seen when abort is set.
  task automatic run(input int hold_pct, input bit burst, input bit mid_start, input bit abort,
                     output int n_start, output int holds);
    int issued, burst_left;
    bit burst_done, h;
    windex   = 0;
    wcount_m = 0;
    wcount_a = 0;
    done_cyc = -1;
    for (int i = 0; i < NUM_MAPS; i++) map_cnt[i] = 0;
    wr_due.delete();
    holds = 0; issued = 0; burst_left = 0; burst_done = 1'b0;

    start     = 1'b1;
    n_start   = cyc;
    busy_from = cyc + 1;
    busy_to   = 32'h7fffffff;
    @(posedge clk); #1;
    start = 1'b0;

    while (issued < READS) begin
      if (abort && wcount_m >= 100) begin
        reset     = 1'b1;
        hold      = 1'b0;
        start     = 1'b0;
        chk_en    = 1'b0;
        exp_rd_en = 1'b0;
        return;
      end
      // Three-cycle hold landing between an even and an odd column read.
      if (burst && !burst_done && issued == 301) begin
        burst_left = 3;
        burst_done = 1'b1;
      end
      h = (burst_left > 0) || ($urandom_range(99) < hold_pct);
      if (burst_left > 0) burst_left--;
      start     = mid_start && (issued == 500);
      hold      = h;
      exp_rd_en = !h;
      if (h) begin
        holds++;
      end else begin
        exp_col = issued % IN_W;
        exp_row = (issued / IN_W) % (IN_H / 2);
        exp_map = issued / (IN_W * IN_H / 2);
        if (issued % 2 == 1) wr_due.push_back(cyc + 2);
        issued++;
        if (issued == READS) busy_to = cyc + 3;
      end
      @(posedge clk); #1;
    end
    hold      = 1'b0;
    start     = 1'b0;
    exp_rd_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int m, input int row, input int col, input int k, input int v);
    mem[m][row][col][k*BD +: BD] = v[BD-1:0];
  endtask

  task automatic end_of_run(input string tag, input int n, input int holds);
    check({tag, ".done_at"}, done_cyc - n, READS + 3 + holds);
    check({tag, ".writes_max"}, wcount_m, WRITES);
    check({tag, ".writes_avg"}, wcount_a, WRITES);
    for (int i = 0; i < NUM_MAPS; i++)
      check($sformatf("%s.map%0d_writes", tag, i), map_cnt[i], PER_MAP);
  endtask

  int lit_px [3][2][4] = '{
    '{'{1, 5, -3, -7}, '{2, 0, -4, -9}},
    '{'{-1, -1, 3, 3}, '{-1, -2, 3, 4}},
    '{'{VMIN, VMIN, VMAX, VMAX}, '{VMIN, VMIN, VMAX, VMAX}}
  };
  int lit_max [2][3] = '{'{5, -1, VMIN}, '{-3, 4, VMAX}};
  int lit_avg [2][3] = '{'{2, -2, VMIN}, '{-6, 3, VMAX}};

  initial begin : p_main
    int n, holds;
    int sel;
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;

    for (int m = 0; m < NUM_MAPS; m++)
      for (int r = 0; r < IN_H; r++)
        for (int c = 0; c < IN_W; c++)
          for (int k = 0; k < CH; k++) begin
            sel = int'($urandom_range(15));
            if (sel == 0)      set_px(m, r, c, k, VMIN);
            else if (sel == 1) set_px(m, r, c, k, VMAX);
            else               set_px(m, r, c, k, int'($urandom()));
          end
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 4; c++)
          set_px(0, r, c, k, lit_px[k][r][c]);

    // Hand-computed results pin the model before it judges the DUT.
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model.max.w%0d.ch%0d", w, k), sx(pool_ref(0, 0, w, 1'b0), k), lit_max[w][k]);
        check($sformatf("model.avg.w%0d.ch%0d", w, k), sx(pool_ref(0, 0, w, 1'b1), k), lit_avg[w][k]);
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.max_ctl", {rd_en_m, rd_col_m, rd_row_m, rd_map_m, wr_en_m, wr_addr_m, wr_map_m, busy_m, done_m}, 0);
    check("rst.max_d", d_m, 0);
    check("rst.avg_ctl", {rd_en_a, rd_col_a, rd_row_a, rd_map_a, wr_en_a, wr_addr_a, wr_map_a, busy_a, done_a}, 0);
    check("rst.avg_d", d_a, 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Run A: no hold.
    run(0, 1'b0, 1'b0, 1'b0, n, holds);
    end_of_run("runA", n, holds);
    check("runA.done_1179", done_cyc - n, 1179);
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("lit.max.w%0d.ch%0d", w, k), sx(cap_m[w], k), lit_max[w][k]);
        check($sformatf("lit.avg.w%0d.ch%0d", w, k), sx(cap_a[w], k), lit_avg[w][k]);
      end

    // Run B: 30% random hold, a 3-cycle burst mid-pair, and a stray start.
    run(30, 1'b1, 1'b1, 1'b0, n, holds);
    end_of_run("runB", n, holds);

    // Run C: reset after the 100th write.
    run(20, 1'b0, 1'b0, 1'b1, n, holds);
    check("abort.reached", wcount_m, 100);
    @(posedge clk);
    @(negedge clk);
    check("abort.max_ctl", {rd_en_m, rd_col_m, rd_row_m, rd_map_m, wr_en_m, wr_addr_m, wr_map_m, busy_m, done_m}, 0);
    check("abort.max_d", d_m, 0);
    check("abort.avg_ctl", {rd_en_a, rd_col_a, rd_row_a, rd_map_a, wr_en_a, wr_addr_a, wr_map_a, busy_a, done_a}, 0);
    check("abort.avg_d", d_a, 0);
    @(posedge clk); #1;
    reset     = 1'b0;
    wr_due.delete();
    busy_from = -1;
    busy_to   = -1;
    exp_rd_en = 1'b0;
    wcount_m  = 0;
    chk_en    = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort.no_writes_after", wcount_m, 0);

    // Run D: fresh start after the abort.
    run(0, 1'b0, 1'b0, 1'b0, n, holds);
    end_of_run("runD", n, holds);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool2d_engine.md
# pool2d_engine

Parametrised 2x2/stride-2 pooling engine for the CNN datapath, the successor to the fixed three-channel max-pool stage. It streams row pairs out of the upstream feature-map BRAMs and supports generic channel count, feature-map size and number of maps per run. It offers max or floor-average mode, and provides an issue-hold input for BRAM arbitration. Pooled results are written into the downstream BRAM with a linear address and a map index, and one done pulse is raised per run.

## Interface
- BD, 18: data width per channel, signed two's complement
- CH, 3: channels processed in parallel
- IN_W, 28: input map width; even, >=2
- IN_H, 28: input map height; even, >=2
- NUM_MAPS, 3: maps pooled per run (replaces fixed bram_num count)
- MODE, 0: 0 = max pool, 1 = average pool
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  single-cycle run request
- hold  in  1  suppress new read issue this cycle
- q0  in  CH*BD  row 2r at rd_col, channel k in bits [k*BD +: BD], valid 1 cycle after issue
- q1  in  CH*BD  row 2r+1, same format
- rd_en  out  1  read issued this cycle
- rd_col  out  clog2(IN_W)  column address
- rd_row  out  clog2(IN_H/2), min 1  row-pair index r
- rd_map  out  clog2(NUM_MAPS), min 1  map being read
- wr_en  out  1  write strobe
- wr_addr  out  clog2(IN_H*IN_W/4)  linear output address r*(IN_W/2)+c
- wr_map  out  clog2(NUM_MAPS), min 1  map being written
- d  out  CH*BD  pooled data, same packing as q0
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse

## Operation
- FSM states:
  - IDLE: start -> RUN; clear rd_col, rd_row and rd_map.
  - RUN: each cycle with hold=0, assert rd_en and advance the counters.
    - rd_col wraps IN_W-1 -> 0 and increments rd_row.
    - rd_row wraps IN_H/2-1 -> 0 and increments rd_map.
    - Issuing the last address (NUM_MAPS-1, IN_H/2-1, IN_W-1) moves the FSM to DRAIN.
  - DRAIN: wait until the last write has issued, then go to DONE.
  - DONE: pulse done for one cycle, go to IDLE.
- start outside IDLE is ignored. busy=1 in RUN, DRAIN and DONE.
- hold=1 freezes the address counters and rd_en=0. In-flight data still completes.
- Pipeline carries a valid tag plus column parity, map index and wr_addr with each issued read.
- Even-column stage: per channel, register V = max(q0,q1) in MODE 0, or S = q0+q1 (BD+1 bits, sign-extended) in MODE 1.
- Odd-column stage, MODE 0: result = max(V, max(q0,q1)), using signed compare.
- Odd-column stage, MODE 1: result = (S + q0 + q1) >>> 2, computed in BD+2 bits with an arithmetic shift (floor toward -inf), then truncated to BD bits (always in range).
- Result is registered into d with wr_en=1. wr_addr increments per write and resets to 0 at each new map.
- A hold between the even and odd column of a pair must not corrupt V/S.

## Timing
- Reset values: rd_en, rd_col, rd_row, rd_map, wr_en, wr_addr, wr_map, d, busy and done all 0; FSM in IDLE.
- Reset mid-run aborts immediately. No done pulse, and no further writes after reset deasserts.
- The start cycle is N, with hold=0 throughout the run:
  - busy=1 from N+1.
  - First rd_en at N+1.
  - Each odd-column read at cycle t produces wr_en at t+2.
- Total reads = NUM_MAPS*(IN_H/2)*IN_W.
- Last read at N+reads. Last write at N+reads+2. done at N+reads+3, and busy=0 at N+reads+4.
- Write count = NUM_MAPS*IN_H*IN_W/4. Each hold cycle delays all later events by 1.
- A new start is accepted in the cycle busy returns to 0.

## Test plan
- MODE 0, IN_W=IN_H=4, CH=1, NUM_MAPS=1: rows 0-1 hold {1,5,-3,-7}/{2,0,-4,-9}. Expect writes wr_addr0=5 and wr_addr1=-3; total 4 writes; done at N+8+3.
- MODE 1, same size: one pair of q0={-1,-1}, q1={-1,-2}. Expect -2 (floor). Second pair {3,3}/{3,4} expects 3.
- Defaults (28x28, 3 maps, CH=3, random data vs model):
  - 588 writes, 196 per map.
  - wr_addr 0..195 per map, wr_map 0..2.
  - done at N+1179.
- hold asserted for 3 cycles between an even and odd column, plus random hold at 30%: data identical to the no-hold run, and done delayed exactly by the number of hold cycles.
- start pulsed mid-run: ignored, write count unchanged.
- reset asserted at write 100: all outputs 0 next cycle. A fresh start then completes normally.
- Extreme values: the max of BD-bit most-negative inputs returns the most negative value. The avg of four most-positive values returns the most positive value, with no overflow.
